spi_reg_bank: RTL and testbench

- Parametrised SPI (mode 0) peripheral register bank, controller-to-peripheral (COPI, nCS, SCLK) plus a new read-back path on CIPO.
- Second generation of the team's SPI config block: configurable register count, data and address width, and per-register reset values.
- Adds reads, a write strobe, and frame/address error reporting.
- Sits between the chip pins and the output-enable/PWM configuration logic; all SPI inputs are oversampled in the clk domain.

---
 rtl/spi_reg_bank_if.sv | 12 +
 rtl/spi_reg_bank.sv | 155 +++++++++++++++
 tb/tb_spi_reg_bank.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between an external controller and the register bank.
// The controller drives clock, data and select; the bank answers on CIPO.
interface spi_reg_bank_if;
  logic SCLK;
  logic COPI;
  logic nCS;
  logic CIPO;
  logic cipo_oe;

  modport master (output SCLK, COPI, nCS, input CIPO, cipo_oe);
  modport slave  (input SCLK, COPI, nCS, output CIPO, cipo_oe);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 register bank: oversampled pins, write commit on nCS rise,
// read-back on CIPO, and error pulses for short frames or bad write addresses.
module spi_reg_bank #(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_reg_bank_if.slave              spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       err
);
  localparam int FRAME = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam logic [CNT_W-1:0]  FRAME_C  = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0]  LAST_C   = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0]  ADDR_END = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  DATA_BEG = CNT_W'(ADDR_W + 1);
  localparam logic [ADDR_W:0]   NREGS_C  = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [2:0] sclk_s, copi_s, ncs_s;
  logic       sclk_rise, sclk_fall, ncs_fall, ncs_rise, copi_bit;

  state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] data_q, rd_val, out_sr;
  logic              oe_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

  logic shift_en, rd_load, closing, frame_full, addr_ok, commit, reject;

  // nCS idles high so a reset release never looks like a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= '0;
      copi_s <= '0;
      ncs_s  <= '1;
    end else begin
      sclk_s <= {sclk_s[1:0], spi.SCLK};
      copi_s <= {copi_s[1:0], spi.COPI};
      ncs_s  <= {ncs_s[1:0],  spi.nCS};
    end
  end

  assign sclk_rise =  sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] &  sclk_s[2];
  assign ncs_fall  = ~ncs_s[1]  &  ncs_s[2];
  assign ncs_rise  =  ncs_s[1]  & ~ncs_s[2];
  assign copi_bit  =  copi_s[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // SCLK edges are only honoured in SHIFT, so nCS fall wins in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (ncs_fall) state_d = SHIFT;
      SHIFT: if (ncs_rise) state_d = IDLE;
             else if (sclk_rise && cnt_q == LAST_C) state_d = DONE;
      DONE:  if (ncs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign shift_en = (state_q == SHIFT) && sclk_rise;
  assign addr_nxt = (addr_q << 1) | ADDR_W'(copi_bit);
  assign rd_load  = shift_en && (cnt_q == ADDR_END) && !rw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rw_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (state_q == IDLE && ncs_fall) begin
      cnt_q  <= '0;
      rw_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (shift_en) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == '0)            rw_q   <= copi_bit;
      else if (cnt_q <= ADDR_END) addr_q <= addr_nxt;
      else                        data_q <= (data_q << 1) | DATA_W'(copi_bit);
    end
  end

  // Out-of-range addresses fall through to zero
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (addr_nxt == ADDR_W'(i)) rd_val = regs_q[i];
  end

  // Data MSB must be on CIPO before the first data-phase rise, so shifting
  // starts on the fall that follows it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sr <= '0;
      oe_q   <= 1'b0;
    end else if (ncs_rise || (state_q == IDLE && ncs_fall)) begin
      out_sr <= '0;
      oe_q   <= 1'b0;
    end else if (rd_load) begin
      out_sr <= rd_val;
      oe_q   <= 1'b1;
    end else if (oe_q && sclk_fall && cnt_q > DATA_BEG) begin
      out_sr <= out_sr << 1;
    end
  end

  assign spi.CIPO    = oe_q & out_sr[DATA_W-1];
  assign spi.cipo_oe = oe_q;

  assign closing    = ncs_rise && (state_q != IDLE);
  assign frame_full = (cnt_q == FRAME_C);
  assign addr_ok    = ({1'b0, addr_q} < NREGS_C);
  assign commit     = closing && rw_q && frame_full && addr_ok;
  assign reject     = closing && ((!frame_full && cnt_q != '0) ||
                                  (rw_q && frame_full && !addr_ok));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_stb  <= 1'b0;
      err     <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_stb <= commit;
      err    <= reject;
      if (commit) wr_addr <= addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= RESET_VAL;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (addr_q == ADDR_W'(i)) regs_q[i] <= data_q;
    end
  end

  assign regs_out = regs_q;
endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for two bank configurations sharing SCLK/COPI with separate
// chip selects; commits and read data are checked against queued expectations.
module tb_spi_reg_bank;
  logic clk = 1'b0;
  logic rst_n;
  logic sclk, copi, ncs_a, ncs_b;

  always #5 clk = ~clk;

  spi_reg_bank_if ifa ();
  spi_reg_bank_if ifb ();
  assign ifa.SCLK = sclk;
  assign ifa.COPI = copi;
  assign ifa.nCS  = ncs_a;
  assign ifb.SCLK = sclk;
  assign ifb.COPI = copi;
  assign ifb.nCS  = ncs_b;

  logic [39:0]  a_regs;
  logic [127:0] b_regs;
  logic         a_stb, b_stb, a_err, b_err;
  logic [6:0]   a_wr_addr;
  logic [2:0]   b_wr_addr;

  spi_reg_bank #(.NUM_REGS(5), .DATA_W(8), .ADDR_W(7), .RESET_VAL(40'h00_0000_0011)) dut_a (
    .clk(clk), .rst_n(rst_n), .spi(ifa), .regs_out(a_regs),
    .wr_stb(a_stb), .wr_addr(a_wr_addr), .err(a_err));

  spi_reg_bank #(.NUM_REGS(8), .DATA_W(16), .ADDR_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .spi(ifb), .regs_out(b_regs),
    .wr_stb(b_stb), .wr_addr(b_wr_addr), .err(b_err));

  typedef struct {
    logic [6:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exq_a[$], exq_b[$];
  logic [15:0] rdq[$];
  logic [4:0][7:0]  mdl_a;
  logic [7:0][15:0] mdl_b;
  int n_cmp = 0, n_bad = 0;
  int a_stb_n = 0, b_stb_n = 0, a_err_n = 0, b_err_n = 0;
  wr_t mon_a, mon_b;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Commit monitor: every strobe must match the oldest queued write
  always @(negedge clk) begin
    if (a_stb) begin
      a_stb_n++;
      chk("a_stb_expected", 128'(exq_a.size() != 0), 128'(1));
      if (exq_a.size() != 0) begin
        mon_a = exq_a.pop_front();
        chk("a_wr_addr", 128'(a_wr_addr), 128'(mon_a.addr));
        chk("a_wr_data", 128'(a_regs[int'(mon_a.addr)*8 +: 8]), 128'(mon_a.data[7:0]));
      end
    end
    if (b_stb) begin
      b_stb_n++;
      chk("b_stb_expected", 128'(exq_b.size() != 0), 128'(1));
      if (exq_b.size() != 0) begin
        mon_b = exq_b.pop_front();
        chk("b_wr_addr", 128'(b_wr_addr), 128'(mon_b.addr[2:0]));
        chk("b_wr_data", 128'(b_regs[int'(mon_b.addr[2:0])*16 +: 16]), 128'(mon_b.data));
      end
    end
    if (a_err) a_err_n++;
    if (b_err) b_err_n++;
  end

  task automatic sclk_bit(input logic b, input bit sel, output logic c, output logic o);
    copi = b;
    repeat (5) @(posedge clk);
    #1;
    c = sel ? ifb.CIPO : ifa.CIPO;
    o = sel ? ifb.cipo_oe : ifa.cipo_oe;
    sclk = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    sclk = 1'b0;
  endtask

  task automatic frame(input bit sel, input int nbits, input logic [31:0] v,
                       output logic [31:0] rd, output logic [31:0] oeb);
    logic c, o;
    rd = '0;
    oeb = '0;
    if (sel) ncs_b = 1'b0; else ncs_a = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int k = 0; k < nbits; k++) begin
      sclk_bit(v[nbits-1-k], sel, c, o);
      rd  = {rd[30:0], c};
      oeb = {oeb[30:0], o};
    end
    repeat (6) @(posedge clk);
    #1;
    if (sel) ncs_b = 1'b1; else ncs_a = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input string tag, input bit sel, input int nbits, input logic [31:0] v,
                      input int exp_stb, input int exp_err,
                      output logic [31:0] rd, output logic [31:0] oeb);
    int s0 = sel ? b_stb_n : a_stb_n;
    int e0 = sel ? b_err_n : a_err_n;
    frame(sel, nbits, v, rd, oeb);
    chk({tag, "_stb"}, 128'((sel ? b_stb_n : a_stb_n) - s0), 128'(exp_stb));
    chk({tag, "_err"}, 128'((sel ? b_err_n : a_err_n) - e0), 128'(exp_err));
    chk({tag, "_regs"}, sel ? b_regs : 128'(a_regs), sel ? 128'(mdl_b) : 128'(mdl_a));
    chk({tag, "_oe_off"}, 128'(sel ? ifb.cipo_oe : ifa.cipo_oe), 128'(0));
  endtask

  task automatic wr_chk(input string tag, input bit sel, input logic [6:0] addr,
                        input logic [15:0] d, input bit ok);
    logic [31:0] v, r, ob;
    wr_t w;
    v = sel ? ((32'h1 << 19) | (32'(addr[2:0]) << 16) | 32'(d))
            : ((32'h1 << 15) | (32'(addr) << 8) | 32'(d[7:0]));
    if (ok) begin
      w.addr = addr;
      w.data = d;
      if (sel) begin exq_b.push_back(w); mdl_b[int'(addr[2:0])] = d; end
      else     begin exq_a.push_back(w); mdl_a[int'(addr)] = d[7:0]; end
    end
    xfer(tag, sel, sel ? 20 : 16, v, ok ? 1 : 0, ok ? 0 : 1, r, ob);
    chk({tag, "_drain"}, 128'(sel ? exq_b.size() : exq_a.size()), 128'(0));
  endtask

  task automatic rd_chk(input string tag, input bit sel, input logic [6:0] addr,
                        input logic [15:0] exp_d);
    logic [31:0] v, r, ob;
    logic [15:0] e;
    int nb = sel ? 20 : 16;
    int aw = sel ? 3 : 7;
    v = sel ? (32'(addr[2:0]) << 16) : (32'(addr) << 8);
    rdq.push_back(exp_d);
    xfer(tag, sel, nb, v, 0, 0, r, ob);
    e = rdq.pop_front();
    chk({tag, "_cipo"}, sel ? 128'(r[15:0]) : 128'(r[7:0]), 128'(e));
    chk({tag, "_oe_pre"}, 128'(ob[nb-1-aw]), 128'(0));
    chk({tag, "_oe_on"},  128'(ob[nb-2-aw]), 128'(1));
  endtask

  initial begin
    logic [31:0] r, ob;
    logic c, o;
    int e0;
    wr_t w;
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs_a = 1'b1;
    ncs_b = 1'b1;
    mdl_a = 40'h11;
    mdl_b = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_a_regs", 128'(a_regs), 128'(mdl_a));
    chk("rst_b_regs", b_regs, 128'(mdl_b));
    chk("rst_a_stb", 128'(a_stb), 128'(0));
    chk("rst_a_err", 128'(a_err), 128'(0));
    chk("rst_a_oe", 128'(ifa.cipo_oe), 128'(0));
    chk("rst_a_cipo", 128'(ifa.CIPO), 128'(0));
    chk("rst_a_wr_addr", 128'(a_wr_addr), 128'(0));
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    wr_chk("wr_a2", 0, 7'd2, 16'h00A5, 1);
    rd_chk("rd_a2", 0, 7'd2, 16'h00A5);
    wr_chk("wr_a9_bad", 0, 7'd9, 16'h003C, 0);
    rd_chk("rd_a9_zero", 0, 7'd9, 16'h0000);

    xfer("short_a1", 0, 12, 32'h815, 0, 1, r, ob);
    w.addr = 7'd4;
    w.data = 16'h007F;
    exq_a.push_back(w);
    mdl_a[4] = 8'h7F;
    xfer("long_a4", 0, 20, 32'h847F0, 1, 0, r, ob);
    rd_chk("rd_a4", 0, 7'd4, 16'h007F);

    wr_chk("wr_a0", 0, 7'd0, 16'h00FF, 1);
    // abort a frame part-way with reset
    ncs_a = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) sclk_bit(k == 0, 0, c, o);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    mdl_a = 40'h11;
    chk("midrst_a_reg0", 128'(a_regs[7:0]), 128'(8'h11));
    chk("midrst_a_regs", 128'(a_regs), 128'(mdl_a));
    chk("midrst_a_wr_addr", 128'(a_wr_addr), 128'(0));
    chk("midrst_a_oe", 128'(ifa.cipo_oe), 128'(0));
    ncs_a = 1'b1;
    e0 = a_err_n;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_err", 128'(a_err_n - e0), 128'(0));
    wr_chk("wr_a3_post", 0, 7'd3, 16'h005A, 1);
    rd_chk("rd_a3_post", 0, 7'd3, 16'h005A);

    wr_chk("wr_b7", 1, 7'd7, 16'hBEEF, 1);
    rd_chk("rd_b7", 1, 7'd7, 16'hBEEF);
    wr_chk("wr_b0", 1, 7'd0, 16'h1234, 1);
    rd_chk("rd_b0", 1, 7'd0, 16'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
